ext_ram_burst_loader: RTL and testbench

EXT_RAM_BURST_LOADER -- requirements
Module: ext_ram_burst_loader

---
 rtl/loader_pkg.sv | 14 +
 rtl/ext_ram_burst_loader_access_timer.sv | 29 ++
 rtl/ext_ram_burst_loader.sv | 145 ++++++++++++++
 tb/tb_ext_ram_burst_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the external-SRAM burst loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } loaderState_e;

  localparam int CHECKSUM_W = 16;

endpackage

// File: rtl/ext_ram_burst_loader_access_timer.sv
// Countdown that sets how many cycles one external read access lasts.
module access_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetB,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Reload on entry to an access; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      count <= {CNT_W{1'b0}};
    end else if (load) begin
      count <= loadValue;
    end else if (count != {CNT_W{1'b0}}) begin
      count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expire = (count == {CNT_W{1'b0}});

endmodule

// File: rtl/ext_ram_burst_loader.sv
// Copies a burst of words from external asynchronous SRAM into an internal RAM.
// Define LOADER_CHECKSUM_EN to add a 16-bit running checksum output.
module ext_ram_burst_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int INT_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  resetB,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     srcAddr,
  input  logic [INT_ADDR_W-1:0] dstAddr,
  input  logic [INT_ADDR_W:0]   length,
  output logic                  busy,
  output logic                  done,
`ifdef LOADER_CHECKSUM_EN
  output logic [CHECKSUM_W-1:0] checksum,
`endif
  output logic                  externalRamCEB,
  output logic                  externalRamWEB,
  output logic                  externalRamOEB,
  output logic [ADDR_W-1:0]     externalRamAddress,
  input  logic [DATA_W-1:0]     externalRamReadData,
  output logic [INT_ADDR_W-1:0] internalRamAddress,
  output logic [DATA_W-1:0]     internalRamWdata,
  output logic                  internalRamCEB,
  output logic                  internalRamWEB
);

  loaderState_e          state;
  loaderState_e          nextState;
  logic [INT_ADDR_W:0]   remaining;
  logic                  timerLoad;
  logic                  timerExpire;

  access_timer #(.CNT_W(4)) uAccessTimer (
    .clk       (clk),
    .resetB    (resetB),
    .load      (timerLoad),
    .loadValue (4'(WAIT_CYCLES - 1)),
    .expire    (timerExpire)
  );

  // Next-state decode; the timer is reloaded on every entry into ACCESS.
  always_comb begin
    nextState = state;
    timerLoad = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != {(INT_ADDR_W+1){1'b0}}) begin
            nextState = ACCESS;
            timerLoad = 1'b1;
          end else begin
            nextState = DONE;
          end
        end else begin
          nextState = IDLE;
        end
      end
      ACCESS: begin
        if (timerExpire) begin
          nextState = CAPTURE;
        end else begin
          nextState = ACCESS;
        end
      end
      CAPTURE: nextState = WRITE;
      WRITE: begin
        if (remaining != (INT_ADDR_W+1)'(1)) begin
          nextState = ACCESS;
          timerLoad = 1'b1;
        end else begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, datapath and strobes; outputs are decoded from nextState so they are registered.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state              <= IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      externalRamCEB     <= 1'b1;
      externalRamOEB     <= 1'b1;
      internalRamCEB     <= 1'b1;
      internalRamWEB     <= 1'b1;
      externalRamAddress <= {ADDR_W{1'b0}};
      internalRamAddress <= {INT_ADDR_W{1'b0}};
      internalRamWdata   <= {DATA_W{1'b0}};
      remaining          <= {(INT_ADDR_W+1){1'b0}};
    end else begin
      state          <= nextState;
      busy           <= (nextState != IDLE);
      done           <= (nextState == DONE);
      externalRamCEB <= !((nextState == ACCESS) || (nextState == CAPTURE));
      externalRamOEB <= !((nextState == ACCESS) || (nextState == CAPTURE));
      internalRamCEB <= (nextState != WRITE);
      internalRamWEB <= (nextState != WRITE);
      if ((state == IDLE) && start) begin
        externalRamAddress <= srcAddr;
        internalRamAddress <= dstAddr;
        remaining          <= length;
      end else if (state == WRITE) begin
        externalRamAddress <= externalRamAddress + ADDR_W'(1);
        internalRamAddress <= internalRamAddress + INT_ADDR_W'(1);
        remaining          <= remaining - (INT_ADDR_W+1)'(1);
      end else begin
        externalRamAddress <= externalRamAddress;
        internalRamAddress <= internalRamAddress;
        remaining          <= remaining;
      end
      if (state == CAPTURE) begin
        internalRamWdata <= externalRamReadData;
      end else begin
        internalRamWdata <= internalRamWdata;
      end
    end
  end

  assign externalRamWEB = 1'b1;

`ifdef LOADER_CHECKSUM_EN
  // Running sum of written words; held from DONE until the next accepted start.
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      checksum <= {CHECKSUM_W{1'b0}};
    end else if ((state == IDLE) && start) begin
      checksum <= {CHECKSUM_W{1'b0}};
    end else if (state == WRITE) begin
      checksum <= checksum + CHECKSUM_W'(internalRamWdata);
    end else begin
      checksum <= checksum;
    end
  end
`endif

endmodule

// File: tb/tb_ext_ram_burst_loader.sv
// Directed self-checking bench for ext_ram_burst_loader (WAIT_CYCLES=2).
module tb_ext_ram_burst_loader;
  import loader_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int INT_ADDR_W = 10;
  localparam int WAIT_CYCLES = 2;

  logic                  clk;
  logic                  resetB;
  logic                  start;
  logic [ADDR_W-1:0]     srcAddr;
  logic [INT_ADDR_W-1:0] dstAddr;
  logic [INT_ADDR_W:0]   length;
  logic                  busy;
  logic                  done;
  logic                  extCEB;
  logic                  extWEB;
  logic                  extOEB;
  logic [ADDR_W-1:0]     extAddr;
  logic [DATA_W-1:0]     extReadData;
  logic [INT_ADDR_W-1:0] intAddr;
  logic [DATA_W-1:0]     intWdata;
  logic                  intCEB;
  logic                  intWEB;
`ifdef LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] checksum;
`endif

  logic [DATA_W-1:0]     extMem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]     readAddrQ[$];
  logic [INT_ADDR_W-1:0] writeAddrQ[$];
  logic [DATA_W-1:0]     writeDataQ[$];
  int                    extActiveCycles;
  int                    intActiveCycles;
  int                    strobeErrCycles;
  logic                  extCebPrev;
  int                    checks;
  int                    failures;
  int                    doneAt;
  int                    doneCount;
  int                    readBase;
  int                    writeBase;
  int                    extBase;
  int                    intBase;

  ext_ram_burst_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INT_ADDR_W(INT_ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk                 (clk),
    .resetB              (resetB),
    .start               (start),
    .srcAddr             (srcAddr),
    .dstAddr             (dstAddr),
    .length              (length),
    .busy                (busy),
    .done                (done),
`ifdef LOADER_CHECKSUM_EN
    .checksum            (checksum),
`endif
    .externalRamCEB      (extCEB),
    .externalRamWEB      (extWEB),
    .externalRamOEB      (extOEB),
    .externalRamAddress  (extAddr),
    .externalRamReadData (extReadData),
    .internalRamAddress  (intAddr),
    .internalRamWdata    (intWdata),
    .internalRamCEB      (intCEB),
    .internalRamWEB      (intWEB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign extReadData = (!extCEB && !extOEB) ? extMem[extAddr] : 8'h00;

  // Bus monitor: logs each external access start and each internal write.
  initial begin
    extActiveCycles = 0;
    intActiveCycles = 0;
    strobeErrCycles = 0;
    extCebPrev = 1'b1;
  end
  always @(posedge clk) begin
    if (resetB) begin
      if (!extCEB) begin
        extActiveCycles <= extActiveCycles + 1;
        if (extCebPrev) readAddrQ.push_back(extAddr);
      end
      if (!intCEB) intActiveCycles <= intActiveCycles + 1;
      if (!intCEB && !intWEB) begin
        writeAddrQ.push_back(intAddr);
        writeDataQ.push_back(intWdata);
      end
      if ((extCEB !== extOEB) || (extWEB !== 1'b1)) strobeErrCycles <= strobeErrCycles + 1;
    end
    extCebPrev <= extCEB;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one start and watches a fixed 40-cycle window; optionally re-pulses start at cycle pokeAt.
  task automatic runTransfer(input logic [ADDR_W-1:0] src, input logic [INT_ADDR_W-1:0] dst,
                             input logic [INT_ADDR_W:0] len, input int pokeAt);
    readBase  = readAddrQ.size();
    writeBase = writeAddrQ.size();
    extBase   = extActiveCycles;
    intBase   = intActiveCycles;
    doneAt    = -1;
    doneCount = 0;
    @(negedge clk);
    srcAddr = src;
    dstAddr = dst;
    length  = len;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        if (doneAt < 0) doneAt = k;
      end
      if (k == 1) checkValue("busyAfterStart", {31'd0, busy}, 32'd1);
      start = (k == pokeAt);
      if (k == pokeAt) begin
        srcAddr = 19'h00055;
        length  = 11'd5;
      end
    end
    checkValue("busyIdleAfter", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [INT_ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (writeBase + idx < writeAddrQ.size()) begin
      checkValue({tag, "_waddr"}, {22'd0, writeAddrQ[writeBase+idx]}, {22'd0, a});
      checkValue({tag, "_wdata"}, {24'd0, writeDataQ[writeBase+idx]}, {24'd0, d});
    end else begin
      checkValue({tag, "_wmissing"}, 32'd0, 32'd1);
    end
  endtask

  task automatic checkRead(input string tag, input int idx, input logic [ADDR_W-1:0] a);
    if (readBase + idx < readAddrQ.size()) begin
      checkValue({tag, "_raddr"}, {13'd0, readAddrQ[readBase+idx]}, {13'd0, a});
    end else begin
      checkValue({tag, "_rmissing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetB   = 1'b0;
    start    = 1'b0;
    srcAddr  = 19'd0;
    dstAddr  = 10'd0;
    length   = 11'd0;
    extMem[19'h00010] = 8'h11;
    extMem[19'h00011] = 8'h22;
    extMem[19'h00012] = 8'h33;
    extMem[19'h00013] = 8'h44;
    extMem[19'h7FFFE] = 8'hA1;
    extMem[19'h7FFFF] = 8'hB2;
    extMem[19'h00000] = 8'hC3;
    extMem[19'h00020] = 8'h5A;
    extMem[19'h00021] = 8'h6B;
    extMem[19'h00100] = 8'hFF;
    extMem[19'h00101] = 8'hFF;
    extMem[19'h00102] = 8'h02;

    repeat (3) @(negedge clk);
    checkValue("rstBusyDone", {30'd0, busy, done}, 32'd0);
    checkValue("rstStrobes", {27'd0, extCEB, extWEB, extOEB, intCEB, intWEB}, 32'h1F);
    checkValue("rstExtAddr", {13'd0, extAddr}, 32'd0);
    checkValue("rstIntAddr", {22'd0, intAddr}, 32'd0);
    checkValue("rstWdata", {24'd0, intWdata}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    checkValue("rstChecksum", {16'd0, checksum}, 32'd0);
`endif
    resetB = 1'b1;
    repeat (2) @(negedge clk);

    // Four-word burst: 4*(2+2)+1 = 17 cycles to done.
    runTransfer(19'h00010, 10'h000, 11'd4, 0);
    checkValue("s1DoneAt", doneAt, 32'd17);
    checkValue("s1DoneCount", doneCount, 32'd1);
    checkValue("s1Writes", writeAddrQ.size() - writeBase, 32'd4);
    checkValue("s1ExtCycles", extActiveCycles - extBase, 32'd12);
    checkWrite("s1w0", 0, 10'h000, 8'h11);
    checkWrite("s1w1", 1, 10'h001, 8'h22);
    checkWrite("s1w2", 2, 10'h002, 8'h33);
    checkWrite("s1w3", 3, 10'h003, 8'h44);
    checkRead("s1r0", 0, 19'h00010);
    checkRead("s1r3", 3, 19'h00013);
`ifdef LOADER_CHECKSUM_EN
    checkValue("s1Checksum", {16'd0, checksum}, 32'h00AA);
`endif

    // Zero length: done next cycle, no RAM traffic.
    runTransfer(19'h00010, 10'h000, 11'd0, 0);
    checkValue("z0DoneAt", doneAt, 32'd1);
    checkValue("z0DoneCount", doneCount, 32'd1);
    checkValue("z0ExtCycles", extActiveCycles - extBase, 32'd0);
    checkValue("z0IntCycles", intActiveCycles - intBase, 32'd0);

    // Both address counters wrap.
    runTransfer(19'h7FFFE, 10'h3FF, 11'd3, 0);
    checkValue("wrDoneAt", doneAt, 32'd13);
    checkRead("wrr0", 0, 19'h7FFFE);
    checkRead("wrr1", 1, 19'h7FFFF);
    checkRead("wrr2", 2, 19'h00000);
    checkWrite("wrw0", 0, 10'h3FF, 8'hA1);
    checkWrite("wrw1", 1, 10'h000, 8'hB2);
    checkWrite("wrw2", 2, 10'h001, 8'hC3);

    // Start re-pulsed while busy is ignored.
    runTransfer(19'h00020, 10'h040, 11'd2, 3);
    checkValue("bsDoneAt", doneAt, 32'd9);
    checkValue("bsDoneCount", doneCount, 32'd1);
    checkValue("bsWrites", writeAddrQ.size() - writeBase, 32'd2);
    checkWrite("bsw1", 1, 10'h041, 8'h6B);

    // Reset during the second word's ACCESS.
    @(negedge clk);
    srcAddr = 19'h00010;
    dstAddr = 10'h080;
    length  = 11'd3;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    checkValue("rmPreCEB", {31'd0, extCEB}, 32'd0);
    resetB = 1'b0;
    #1;
    checkValue("rmStrobes", {27'd0, extCEB, extWEB, extOEB, intCEB, intWEB}, 32'h1F);
    checkValue("rmBusy", {31'd0, busy}, 32'd0);
    doneCount = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) doneCount++;
      if (k == 2) resetB = 1'b1;
    end
    checkValue("rmNoDone", doneCount, 32'd0);
    runTransfer(19'h00012, 10'h050, 11'd1, 0);
    checkValue("rmNewDoneAt", doneAt, 32'd5);
    checkWrite("rmw0", 0, 10'h050, 8'h33);

`ifdef LOADER_CHECKSUM_EN
    runTransfer(19'h00100, 10'h000, 11'd3, 0);
    checkValue("csSum", {16'd0, checksum}, 32'h0200);
`endif

    checkValue("strobeConsistency", strobeErrCycles, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
